// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer downstream of the core PLL.
// Waits for PLL lock to be stable for LOCK_CYCLES synced cycles before
// releasing sys_reset. Stretches user reset requests. Generates
// phase-aligned single-cycle clock enables ce_a/ce_b. Counts lock losses
// seen while running.
// Optional feature macro: PLL_RESET_SEQ_CE_IN_RESET_EN. When it is defined,
// the enable divider free-runs in every state. Its phase is continuous
// across reset because only rst clears it.
module pll_reset_seq #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int USER_STRETCH = 16,
  parameter int CE_DIV_A     = 4,
  parameter int CE_DIV_B     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       user_reset,
  output logic       sys_reset,
  output logic       ce_a,
  output logic       ce_b,
  output logic       running,
  output logic [7:0] lock_lost_cnt
);

  localparam int LW = $clog2(LOCK_CYCLES);
  localparam int SW = $clog2(USER_STRETCH + 1);
  localparam int AW = $clog2(CE_DIV_A);
  localparam int BW = $clog2(CE_DIV_B);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_COUNT = 2'd1,
    S_USER  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            lock_meta_q, locked_s_q;
  logic            user_meta_q, user_s_q;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   str_q, str_d;
  logic [AW-1:0]   a_cnt_q, a_cnt_d;
  logic [BW-1:0]   b_cnt_q, b_cnt_d;
  logic [7:0]      lost_q, lost_d;
  logic            ce_adv_s;
  logic            sys_reset_q, sys_reset_d;
  logic            running_q, running_d;
  logic            ce_a_q, ce_a_d;
  logic            ce_b_q, ce_b_d;

  // Two-flop synchronisers for the asynchronous lock and user-reset inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
      user_meta_q <= 1'b0;
      user_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      locked_s_q  <= lock_meta_q;
      user_meta_q <= user_reset;
      user_s_q    <= user_meta_q;
    end
  end

  // Sequencer next state, lock window / stretch counters and lock-loss count
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    str_d   = '0;
    lost_d  = lost_q;
    case (state_q)
      S_WAIT: begin
        if (locked_s_q) begin
          state_d = S_COUNT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_COUNT: begin
        // Any lock dropout discards the partial window.
        if (!locked_s_q) begin
          state_d = S_WAIT;
        end else if (cnt_q == LW'(LOCK_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      S_USER: begin
        // Lock loss here is not counted: the core was already held in reset.
        if (!locked_s_q) begin
          state_d = S_WAIT;
        end else if (user_s_q) begin
          str_d = '0;
        end else if (str_q == SW'(USER_STRETCH - 1)) begin
          state_d = S_RUN;
        end else begin
          str_d = str_q + SW'(1);
        end
      end
      S_RUN: begin
        // Lock loss has priority over a simultaneous user request.
        if (!locked_s_q) begin
          state_d = S_WAIT;
          lost_d  = (lost_q == 8'd255) ? lost_q : lost_q + 8'd1;
        end else if (user_s_q) begin
          state_d = S_USER;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // Enable divider: counters advance only when running, or always when the free-run option is enabled
  always_comb begin
`ifdef PLL_RESET_SEQ_CE_IN_RESET_EN
    ce_adv_s = 1'b1;
`else
    ce_adv_s = (state_q == S_RUN) && (state_d == S_RUN);
`endif
    if (ce_adv_s) begin
      a_cnt_d = (a_cnt_q == AW'(CE_DIV_A - 1)) ? '0 : a_cnt_q + AW'(1);
      b_cnt_d = (b_cnt_q == BW'(CE_DIV_B - 1)) ? '0 : b_cnt_q + BW'(1);
    end else begin
      a_cnt_d = '0;
      b_cnt_d = '0;
    end
    // Cleared counters never match the terminal value, so no extra gating is needed.
    ce_a_d      = (a_cnt_d == AW'(CE_DIV_A - 1));
    ce_b_d      = (b_cnt_d == BW'(CE_DIV_B - 1));
    sys_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
  end

  // State, counter and registered-output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      str_q       <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      lost_q      <= 8'd0;
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
      ce_a_q      <= 1'b0;
      ce_b_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      str_q       <= str_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      lost_q      <= lost_d;
      sys_reset_q <= sys_reset_d;
      running_q   <= running_d;
      ce_a_q      <= ce_a_d;
      ce_b_q      <= ce_b_d;
    end
  end

  assign sys_reset     = sys_reset_q;
  assign running       = running_q;
  assign ce_a          = ce_a_q;
  assign ce_b          = ce_b_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq (default build, free-run option off).
module tb_pll_reset_seq;

  localparam int LC = 8;
  localparam int US = 4;
  localparam int DA = 4;
  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       user_reset;
  logic       sys_reset;
  logic       ce_a;
  logic       ce_b;
  logic       running;
  logic [7:0] lock_lost_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: input delay line plus lock/user streak bookkeeping
  int p1, p2, u1, u2;
  bit m_run;
  int m_mode;    // 0: waiting for a stable lock window, 1: stretching a user reset
  int streak;    // consecutive synced-lock observations while not running
  int ustreak;   // consecutive synced user-low observations while stretching
  int phase;     // RUN cycles since entry, first RUN cycle is 0
  int lost;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .LOCK_CYCLES (LC),
    .USER_STRETCH(US),
    .CE_DIV_A    (DA),
    .CE_DIV_B    (DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .user_reset   (user_reset),
    .sys_reset    (sys_reset),
    .ce_a         (ce_a),
    .ce_b         (ce_b),
    .running      (running),
    .lock_lost_cnt(lock_lost_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    p1 = 0; p2 = 0; u1 = 0; u2 = 0;
    m_run = 1'b0; m_mode = 0; streak = 0; ustreak = 0; phase = 0; lost = 0;
  endtask

  task automatic model_edge();
    int ls;
    int us;
    ls = p2; us = u2;
    p2 = p1; p1 = int'(pll_locked);
    u2 = u1; u1 = int'(user_reset);
    if (m_run) begin
      if (ls == 0) begin
        m_run = 1'b0; m_mode = 0; streak = 0;
        if (lost < 255) lost++;
      end else if (us != 0) begin
        m_run = 1'b0; m_mode = 1; ustreak = 0;
      end else begin
        phase++;
      end
    end else if (m_mode == 1) begin
      if (ls == 0) begin
        m_mode = 0; streak = 0;
      end else if (us != 0) begin
        ustreak = 0;
      end else begin
        ustreak++;
        if (ustreak == US) begin m_run = 1'b1; phase = 0; end
      end
    end else begin
      if (ls != 0) begin
        streak++;
        if (streak == LC + 1) begin m_run = 1'b1; phase = 0; end
      end else begin
        streak = 0;
      end
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic ea, eb;
    ea = m_run && ((phase % DA) == DA - 1);
    eb = m_run && ((phase % DB) == DB - 1);
    return {!m_run, m_run, ea, eb, 8'(lost)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check("cycle", 32'({sys_reset, running, ce_a, ce_b, lock_lost_cnt}), 32'(exp_vec()));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_run(input int max, input int exp_edges, input string tag);
    int e;
    e = 0;
    while (!running && e < max) begin tick(); e++; end
    check({tag, "_timeout"}, 32'(running), 32'd1);
    if (exp_edges >= 0) check(tag, 32'(e), 32'(exp_edges));
  endtask

  task automatic wait_drop(input int max, input int exp_edges, input string tag);
    int e;
    e = 0;
    while (running && e < max) begin tick(); e++; end
    check({tag, "_timeout"}, 32'(running), 32'd0);
    if (exp_edges >= 0) check(tag, 32'(e), 32'(exp_edges));
  endtask

  // Called on the first RUN cycle: finds the RUN cycle index of the first ce_a/ce_b
  task automatic ce_phase(input string tag);
    int fa, fb;
    fa = 0; fb = 0;
    for (int k = 1; k <= DB; k++) begin
      if (k > 1) tick();
      if (ce_a && fa == 0) fa = k;
      if (ce_b && fb == 0) fb = k;
    end
    check({tag, "_first_ce_a"}, 32'(fa), 32'(DA));
    check({tag, "_first_ce_b"}, 32'(fb), 32'(DB));
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; user_reset = 1'b0;
    model_reset();

    // Power-up
    cycles(3);
    rst = 1'b0;
    check("reset_state", 32'({sys_reset, running, ce_a, ce_b, lock_lost_cnt}), 32'h800);
    pll_locked = 1'b1;
    wait_run(40, LC + 3, "powerup_release");
    check("powerup_sys_reset", 32'(sys_reset), 32'd0);
    ce_phase("powerup");

    // User reset pulse of 10 cycles while running
    user_reset = 1'b1;
    wait_drop(10, 3, "user_enter");
    cycles(7);
    user_reset = 1'b0;
    wait_run(20, 2 + US, "user_release");
    ce_phase("user");
    check("user_lost_cnt", 32'(lock_lost_cnt), 32'd0);

    // Three lock losses while running
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      wait_drop(10, 3, "loss_drop");
      cycles($urandom_range(0, 5));
      pll_locked = 1'b1;
      wait_run(30, LC + 3, "loss_recover");
      check("loss_cnt", 32'(lock_lost_cnt), 32'(i + 1));
    end

    // Lock loss and user request on the same edge: lock loss wins
    pll_locked = 1'b0; user_reset = 1'b1;
    wait_drop(10, 3, "simul_drop");
    cycles(5);
    check("simul_cnt", 32'(lock_lost_cnt), 32'd4);
    pll_locked = 1'b1; user_reset = 1'b0;
    wait_run(30, LC + 3, "simul_recover");

    // Randomised user pulses
    for (int i = 0; i < 6; i++) begin
      cycles($urandom_range(0, 20));
      user_reset = 1'b1;
      cycles($urandom_range(1, 12));
      user_reset = 1'b0;
      cycles(12);
      wait_run(20, -1, "user_rand");
    end
    check("user_rand_cnt", 32'(lock_lost_cnt), 32'd4);

    // Asynchronous rst while in COUNT
    pll_locked = 1'b0;
    cycles(4);
    pll_locked = 1'b1;
    cycles(5);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 32'({sys_reset, running, ce_a, ce_b, lock_lost_cnt}), 32'h800);
    model_reset();
    cycles(2);
    rst = 1'b0;

    // Lock glitch during COUNT after 5 synced-lock cycles
    cycles(7);
    pll_locked = 1'b0;
    cycles(3);
    pll_locked = 1'b1;
    wait_run(30, LC + 3, "glitch_recover");
    check("glitch_lost_cnt", 32'(lock_lost_cnt), 32'd0);

    // Saturation: 300 lock losses with random dropout lengths
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      cycles($urandom_range(1, 6));
      pll_locked = 1'b1;
      cycles(3);
      wait_run(40, -1, "sat_recover");
    end
    check("sat_cnt", 32'(lock_lost_cnt), 32'd255);
    pll_locked = 1'b0;
    wait_drop(10, 3, "sat_extra_drop");
    pll_locked = 1'b1;
    wait_run(30, LC + 3, "sat_extra_recover");
    check("sat_hold", 32'(lock_lost_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
